ex_wb: RTL and testbench
========================

// Module: ex_wb
// PURPOSE
//  EX->WB pipeline register plus write-back stage of the RISC-V core. Captures EX results
//  and control, formats synchronous-BRAM load data, selects the final write-back value, and
//  drives wb_data/wb_addr/is_wb to the regfile and to the ID/EX bypass. Also keeps the
//  cycle and instret counters for the CSR read path.
// PARAMETERS
//  DWIDTH   32  datapath width (fixed at 32 for RV32I)
//  CNT_W    32  width of cycle_cnt_o / instret_cnt_o
// PORTS
//  clk             in   1       core clock
//  rst             in   1       synchronous, active-high reset
//  stall_i         in   1       hold every WB-stage register this cycle
//  flush_i         in   1       capture a bubble instead of the EX instruction
//  alu_result_i    in   32      EX ALU result (load address for loads)
//  pc_plus_i       in   32      PC+4 of the EX instruction
//  csr_rdata_i     in   32      CSR/MMIO read data produced in EX
//  rd_addr_i       in   5       destination register
//  control_wb_i    in   1       instruction writes rd
//  control_wr_mux_i in  2       00 ALU, 01 load data, 10 PC+4, 11 CSR/MMIO data
//  control_load_i  in   3       load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  dmem_rdata_i    in   32      BRAM read word, valid the cycle after EX presents address
//  wb_data_o       out  32      final write-back value (combinational in WB)
//  wb_addr_o       out  5       registered rd
//  is_wb_o         out  1       write enable to regfile and ID/EX bypass
//  cycle_cnt_o     out  CNT_W   cycles since reset
//  instret_cnt_o   out  CNT_W   instructions retired since reset
// BEHAVIOUR
//  - Registers: valid_q, alu_q, pcp_q, csr_q, rd_q, wb_q, mux_q, load_q. All reset to 0.
//    After reset: wb_data_o=0, wb_addr_o=0, is_wb_o=0, both counters 0.
//  - Capture per rising edge: rst > stall_i (hold all) > flush_i (valid_q<=0, others
//    don't-care but forced 0) > normal (valid_q<=1, all fields <= inputs).
//  - stall_i and flush_i together: stall wins; hazard unit must keep flush_i asserted.
//  - Latency: EX inputs sampled at edge N -> wb_* valid during cycle N+1.
//    dmem_rdata_i is used combinationally in cycle N+1 (one-cycle BRAM read).
//  - is_wb_o = valid_q & wb_q & (rd_q != 0). x0 is never written.
//    Held high across a stall (repeating the write is harmless).
//  - Load format, off = alu_q[1:0]:
//    LB/LBU select byte off (sign/zero extend).
//    LH/LHU select halfword off[1] (off[0] ignored, no trap).
//    LW ignores off.
//    Undefined load_q encodings return the raw word.
//  - wb_data_o mux per mux_q. When valid_q=0, wb_data_o=0.
//  - cycle_cnt_o += 1 every non-reset cycle, including stalls. Wraps 2^CNT_W-1 -> 0.
//  - instret_cnt_o += 1 on cycles with valid_q & ~stall_i, so a stalled instruction
//    counts once. Wraps to 0.
//  - Reset mid-operation: the in-flight instruction is dropped (is_wb_o=0 next cycle).
//    Counters clear.
// TESTING
//  1. Reset held 3 cycles, then released.
//     -> all outputs 0; cycle_cnt_o=1 one cycle after release.
//  2. ALU op rd=5, result 0x1234_5678, wb=1, mux=00.
//     -> next cycle is_wb_o=1, wb_addr_o=5, wb_data_o=0x12345678; instret +1.
//  3. Load, dmem_rdata_i=0x80FF_7F01:
//     - LB off=1   -> 0x7F
//     - LB off=2   -> 0xFFFFFFFF
//     - LBU off=3  -> 0x80
//     - LH off=2   -> 0xFFFF80FF
//     - LHU off=0  -> 0x7F01
//     - LW         -> 0x80FF7F01
//  4. JAL rd=1, pc_plus_i=0x104, mux=10 -> wb_data_o=0x104.
//     Same with rd=0 -> is_wb_o=0, instret still +1.
//  5. stall_i high 2 cycles during a valid instruction.
//     -> wb outputs held constant; instret +1 total; cycle_cnt +2.
//     Stall+flush together -> held.
//  6. flush_i with valid EX inputs -> is_wb_o=0, wb_data_o=0, instret unchanged.
//     Preload counters to all-ones -> wrap to 0.

Source files
------------

// File: rtl/ex_wb_if.sv
// EX->WB bundle: EX-side results/control in, write-back and CSR counter values out.
// master = EX/hazard side, slave = the ex_wb stage.
interface ex_wb_if #(
    parameter int DWIDTH = 32,
    parameter int CNT_W  = 32
);
    logic              stall_i;
    logic              flush_i;
    logic [DWIDTH-1:0] alu_result_i;
    logic [DWIDTH-1:0] pc_plus_i;
    logic [DWIDTH-1:0] csr_rdata_i;
    logic [4:0]        rd_addr_i;
    logic              control_wb_i;
    logic [1:0]        control_wr_mux_i;
    logic [2:0]        control_load_i;
    logic [DWIDTH-1:0] dmem_rdata_i;
    logic [DWIDTH-1:0] wb_data_o;
    logic [4:0]        wb_addr_o;
    logic              is_wb_o;
    logic [CNT_W-1:0]  cycle_cnt_o;
    logic [CNT_W-1:0]  instret_cnt_o;

    modport master (
        output stall_i, flush_i, alu_result_i, pc_plus_i, csr_rdata_i, rd_addr_i,
               control_wb_i, control_wr_mux_i, control_load_i, dmem_rdata_i,
        input  wb_data_o, wb_addr_o, is_wb_o, cycle_cnt_o, instret_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, alu_result_i, pc_plus_i, csr_rdata_i, rd_addr_i,
               control_wb_i, control_wr_mux_i, control_load_i, dmem_rdata_i,
        output wb_data_o, wb_addr_o, is_wb_o, cycle_cnt_o, instret_cnt_o
    );
endinterface

// File: rtl/ex_wb.sv
// EX->WB pipeline register and write-back stage: load formatting, write-back select,
// and the cycle/instret counters feeding the CSR read path.
module ex_wb #(
    parameter int DWIDTH = 32,
    parameter int CNT_W  = 32
) (
    input  logic   clk,
    input  logic   rst,
    ex_wb_if.slave bus
);
    typedef enum logic [1:0] {
        WR_ALU  = 2'b00,
        WR_LOAD = 2'b01,
        WR_PC4  = 2'b10,
        WR_CSR  = 2'b11
    } wr_mux_e;

    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_BU = 3'b100,
        LD_HU = 3'b101
    } load_e;

    logic              r_valid_q;
    logic [DWIDTH-1:0] r_alu_q;
    logic [DWIDTH-1:0] r_pcp_q;
    logic [DWIDTH-1:0] r_csr_q;
    logic [4:0]        r_rd_q;
    logic              r_wb_q;
    logic [1:0]        r_mux_q;
    logic [2:0]        r_load_q;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic [CNT_W-1:0]  r_instret_cnt;

    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DWIDTH-1:0] w_load_data;
    logic [DWIDTH-1:0] w_wb_data;

    // Priority: reset, then stall (hold everything), then flush (bubble), then capture.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_alu_q   <= '0;
            r_pcp_q   <= '0;
            r_csr_q   <= '0;
            r_rd_q    <= '0;
            r_wb_q    <= 1'b0;
            r_mux_q   <= '0;
            r_load_q  <= '0;
        end else if (!bus.stall_i) begin
            if (bus.flush_i) begin
                r_valid_q <= 1'b0;
                r_alu_q   <= '0;
                r_pcp_q   <= '0;
                r_csr_q   <= '0;
                r_rd_q    <= '0;
                r_wb_q    <= 1'b0;
                r_mux_q   <= '0;
                r_load_q  <= '0;
            end else begin
                r_valid_q <= 1'b1;
                r_alu_q   <= bus.alu_result_i;
                r_pcp_q   <= bus.pc_plus_i;
                r_csr_q   <= bus.csr_rdata_i;
                r_rd_q    <= bus.rd_addr_i;
                r_wb_q    <= bus.control_wb_i;
                r_mux_q   <= bus.control_wr_mux_i;
                r_load_q  <= bus.control_load_i;
            end
        end
    end

    // The instret increment is gated by stall so a held instruction retires once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (r_valid_q && !bus.stall_i) begin
                r_instret_cnt <= r_instret_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
    always_comb begin
        w_byte      = bus.dmem_rdata_i[8*r_alu_q[1:0] +: 8];
        w_half      = r_alu_q[1] ? bus.dmem_rdata_i[31:16] : bus.dmem_rdata_i[15:0];
        w_load_data = bus.dmem_rdata_i;
        case (load_e'(r_load_q))
            LD_B:    w_load_data = {{24{w_byte[7]}}, w_byte};
            LD_BU:   w_load_data = {24'b0, w_byte};
            LD_H:    w_load_data = {{16{w_half[15]}}, w_half};
            LD_HU:   w_load_data = {16'b0, w_half};
            LD_W:    w_load_data = bus.dmem_rdata_i;
            default: w_load_data = bus.dmem_rdata_i;
        endcase
    end

    always_comb begin
        w_wb_data = '0;
        if (r_valid_q) begin
            case (wr_mux_e'(r_mux_q))
                WR_ALU:  w_wb_data = r_alu_q;
                WR_LOAD: w_wb_data = w_load_data;
                WR_PC4:  w_wb_data = r_pcp_q;
                WR_CSR:  w_wb_data = r_csr_q;
                default: w_wb_data = '0;
            endcase
        end
    end

    assign bus.wb_data_o     = w_wb_data;
    assign bus.wb_addr_o     = r_rd_q;
    assign bus.is_wb_o       = r_valid_q & r_wb_q & (r_rd_q != 5'd0);
    assign bus.cycle_cnt_o   = r_cycle_cnt;
    assign bus.instret_cnt_o = r_instret_cnt;
endmodule

// File: tb/tb_ex_wb.sv
// Self-checking bench for ex_wb: directed write-back/load/stall/flush steps, then random
// traffic against an instruction-level reference model. Counters run narrow to reach wrap.
module tb_ex_wb;
    localparam int CW = 6;
    localparam int unsigned CMASK = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_wb_if #(.DWIDTH(32), .CNT_W(CW)) bus ();
    ex_wb #(.DWIDTH(32), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // The instruction currently sitting in write-back, as the architecture sees it.
    typedef struct {
        bit          v;
        logic [31:0] alu;
        logic [31:0] pcp;
        logic [31:0] csr;
        logic [4:0]  rd;
        bit          wb;
        logic [1:0]  mux;
        logic [2:0]  ld;
    } slot_t;

    slot_t       m;
    int unsigned m_cyc;
    int unsigned m_ret;
    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] dm;
    logic [CW-1:0] saved_ret;
    logic [CW-1:0] saved_cyc;
    logic [31:0] saved_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] exp_data(input slot_t s, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        if (!s.v) return 32'h0;
        b = 8'(d >> (8 * s.alu[1:0]));
        h = 16'(d >> (16 * s.alu[1]));
        case (s.mux)
            2'd0: return s.alu;
            2'd2: return s.pcp;
            2'd3: return s.csr;
            default: begin
                case (s.ld)
                    3'b000:  return {{24{b[7]}}, b};
                    3'b100:  return {24'h0, b};
                    3'b001:  return {{16{h[15]}}, h};
                    3'b101:  return {16'h0, h};
                    default: return d;
                endcase
            end
        endcase
    endfunction

    task automatic set_ex(input logic [4:0] rd, input logic wb, input logic [1:0] mux,
                          input logic [2:0] ld, input logic [31:0] alu,
                          input logic [31:0] pcp, input logic [31:0] csr);
        bus.rd_addr_i        = rd;
        bus.control_wb_i     = wb;
        bus.control_wr_mux_i = mux;
        bus.control_load_i   = ld;
        bus.alu_result_i     = alu;
        bus.pc_plus_i        = pcp;
        bus.csr_rdata_i      = csr;
    endtask

    // One clock: advance the model at the edge, present BRAM data, then check all outputs.
    task automatic tick(input logic [31:0] dmem, input string tag);
        @(posedge clk);
        if (rst) begin
            m = '{default: '0};
            m_cyc = 0;
            m_ret = 0;
        end else begin
            m_cyc++;
            if (m.v && !bus.stall_i) m_ret++;
            if (!bus.stall_i) begin
                if (bus.flush_i) begin
                    m = '{default: '0};
                end else begin
                    m.v   = 1'b1;
                    m.alu = bus.alu_result_i;
                    m.pcp = bus.pc_plus_i;
                    m.csr = bus.csr_rdata_i;
                    m.rd  = bus.rd_addr_i;
                    m.wb  = bus.control_wb_i;
                    m.mux = bus.control_wr_mux_i;
                    m.ld  = bus.control_load_i;
                end
            end
        end
        #1 bus.dmem_rdata_i = dmem;
        #1;
        check({tag, ".is_wb"}, 32'(bus.is_wb_o), 32'(m.v && m.wb && (m.rd != 5'd0)));
        check({tag, ".addr"}, 32'(bus.wb_addr_o), 32'(m.rd));
        check({tag, ".data"}, bus.wb_data_o, exp_data(m, dmem));
        check({tag, ".cycle"}, 32'(bus.cycle_cnt_o), m_cyc & CMASK);
        check({tag, ".instret"}, 32'(bus.instret_cnt_o), m_ret & CMASK);
    endtask

    initial begin
        m = '{default: '0};
        m_cyc = 0;
        m_ret = 0;
        rst = 1'b1;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.dmem_rdata_i = '0;
        set_ex(5'd0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);

        // Reset for 3 cycles, release with a bubble in EX.
        repeat (3) tick(32'h0, "reset");
        rst = 1'b0;
        bus.flush_i = 1'b1;
        tick(32'h0, "rel");
        check("rel.cycle_is_1", 32'(bus.cycle_cnt_o), 32'd1);
        check("rel.data_zero", bus.wb_data_o, 32'h0);
        bus.flush_i = 1'b0;

        // ALU write-back.
        set_ex(5'd5, 1'b1, 2'b00, 3'b010, 32'h1234_5678, 32'h0, 32'h0);
        tick(32'h0, "alu");
        check("alu.const", bus.wb_data_o, 32'h1234_5678);

        // Loads from 0x80FF_7F01, one instruction per cycle.
        dm = 32'h80FF_7F01;
        set_ex(5'd6, 1'b1, 2'b01, 3'b000, 32'h1001, 32'h0, 32'h0);
        tick(dm, "lb1");
        check("lb1.const", bus.wb_data_o, 32'h0000_007F);
        set_ex(5'd6, 1'b1, 2'b01, 3'b000, 32'h1002, 32'h0, 32'h0);
        tick(dm, "lb2");
        check("lb2.const", bus.wb_data_o, 32'hFFFF_FFFF);
        set_ex(5'd6, 1'b1, 2'b01, 3'b100, 32'h1003, 32'h0, 32'h0);
        tick(dm, "lbu3");
        check("lbu3.const", bus.wb_data_o, 32'h0000_0080);
        set_ex(5'd6, 1'b1, 2'b01, 3'b001, 32'h1002, 32'h0, 32'h0);
        tick(dm, "lh2");
        check("lh2.const", bus.wb_data_o, 32'hFFFF_80FF);
        set_ex(5'd6, 1'b1, 2'b01, 3'b101, 32'h1000, 32'h0, 32'h0);
        tick(dm, "lhu0");
        check("lhu0.const", bus.wb_data_o, 32'h0000_7F01);
        set_ex(5'd6, 1'b1, 2'b01, 3'b010, 32'h1003, 32'h0, 32'h0);
        tick(dm, "lw");
        check("lw.const", bus.wb_data_o, 32'h80FF_7F01);
        set_ex(5'd6, 1'b1, 2'b01, 3'b111, 32'h1001, 32'h0, 32'h0);
        tick(dm, "ld_undef");

        // JAL link write, then the same with rd=x0.
        set_ex(5'd1, 1'b1, 2'b10, 3'b000, 32'h0000_0200, 32'h104, 32'h0);
        tick(32'h0, "jal");
        check("jal.const", bus.wb_data_o, 32'h104);
        set_ex(5'd0, 1'b1, 2'b10, 3'b000, 32'h0000_0200, 32'h104, 32'h0);
        saved_ret = bus.instret_cnt_o;
        tick(32'h0, "jal_x0");
        check("jal_x0.is_wb", 32'(bus.is_wb_o), 32'd0);

        // CSR read, then stall two cycles with it in WB; flush rides along on the second.
        set_ex(5'd9, 1'b1, 2'b11, 3'b000, 32'h0, 32'h0, 32'hCAFE_F00D);
        tick(32'h0, "csr");
        saved_data = bus.wb_data_o;
        saved_cyc  = bus.cycle_cnt_o;
        saved_ret  = bus.instret_cnt_o;
        set_ex(5'd3, 1'b1, 2'b00, 3'b000, 32'hDEAD_0000, 32'h0, 32'h0);
        bus.stall_i = 1'b1;
        tick(32'h0, "stall1");
        bus.flush_i = 1'b1;
        tick(32'h0, "stall2_flush");
        check("stall.held_data", bus.wb_data_o, saved_data);
        check("stall.cycle+2", 32'(bus.cycle_cnt_o), 32'((saved_cyc + CW'(2))));
        bus.stall_i = 1'b0;
        tick(32'h0, "flush");
        check("stall.instret+1", 32'(bus.instret_cnt_o), 32'((saved_ret + CW'(1))));
        check("flush.data_zero", bus.wb_data_o, 32'h0);
        bus.flush_i = 1'b0;

        // Reset mid-operation drops the in-flight instruction.
        tick(32'h0, "before_rst");
        rst = 1'b1;
        tick(32'h0, "mid_rst");
        check("mid_rst.is_wb", 32'(bus.is_wb_o), 32'd0);
        rst = 1'b0;

        // Run past 2^CW cycles so the cycle counter wraps.
        for (int i = 0; i < (1 << CW); i++) begin
            set_ex(5'(i), 1'b1, 2'b00, 3'b000, 32'(i * 7), 32'h0, 32'h0);
            tick(32'h0, "wrap_run");
        end
        check("wrap.cycle_zero", 32'(bus.cycle_cnt_o), 32'd0);

        // Random traffic, occasional stall/flush/reset.
        for (int i = 0; i < 300; i++) begin
            set_ex(5'($urandom), 1'($urandom), 2'($urandom), 3'($urandom),
                   $urandom, $urandom, $urandom);
            bus.stall_i = ($urandom_range(0, 7) == 0);
            bus.flush_i = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 59) == 0);
            tick($urandom, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
